// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner: FSM encodings, LED line geometry
// and the 8-bit Fibonacci LFSR shared by the sequencer and obstacle generator.
package dino_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } state_e;

    localparam int              LFSR_W    = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam int              DINO_COL  = 0;
    localparam int              LINE_W    = 8;

    // Feedback bit of the taps-8,6,5,4 register; it becomes bit0 of the next value.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] v);
        return ^(v & LFSR_TAPS);
    endfunction

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], lfsr_fb(v)};
    endfunction

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Button/obstacle/status bundle between the game sequencer and its environment.
// Suffixes are from the sequencer's point of view.
interface dino_game_ctrl_if import dino_pkg::*; #(
    parameter int SCORE_W = 8
) ();
    logic               start_btn_i;
    logic               jump_btn_i;
    logic [LINE_W-1:0]  obst_line_i;
    logic               obst_step_o;
    logic               obst_spawn_o;
    logic               obst_clear_o;
    logic               dino_up_o;
    logic               game_over_o;
    logic [SCORE_W-1:0] score_o;
    logic [1:0]         state_o;

    modport slave (
        input  start_btn_i, jump_btn_i, obst_line_i,
        output obst_step_o, obst_spawn_o, obst_clear_o, dino_up_o,
               game_over_o, score_o, state_o
    );

    modport master (
        output start_btn_i, jump_btn_i, obst_line_i,
        input  obst_step_o, obst_spawn_o, obst_clear_o, dino_up_o,
               game_over_o, score_o, state_o
    );
endinterface

// File: rtl/dino_lfsr8.sv
// Free-standing 8-bit Fibonacci LFSR that advances only when enabled.
module dino_lfsr8 import dino_pkg::*; #(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    output logic [LFSR_W-1:0] value_o
);
    logic [LFSR_W-1:0] lfsr_q;

    // LFSR state register: holds unless advanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

    assign value_o = lfsr_q;
endmodule

// File: rtl/dino_game_ctrl.sv
// Game sequencer for the 8-LED dino runner: IDLE/RUN/DEAD FSM, scroll-tick
// prescaler, obstacle step/spawn/clear commands, jump timer, collision and score.
module dino_game_ctrl import dino_pkg::*; #(
    parameter int                TICK_DIV   = 4,
    parameter int                JUMP_TICKS = 3,
    parameter int                MIN_GAP    = 2,
    parameter int                SCORE_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    dino_game_ctrl_if.slave   bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int JW = $clog2(JUMP_TICKS + 1);
    localparam int GW = $clog2(MIN_GAP + 2);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [JW-1:0] JUMP_LOAD = JW'(JUMP_TICKS);
    localparam logic [GW-1:0] GAP_MAX   = GW'(MIN_GAP);

    state_e             state_q;
    logic               start_prev_q, jump_prev_q;
    logic [PW-1:0]      presc_q;
    logic [GW-1:0]      gap_q;
    logic [JW-1:0]      jump_cnt_q, jump_cnt_d;
    logic [SCORE_W-1:0] score_q;
    logic               step_q, spawn_q, clear_q, dino_up_q, game_over_q;
    logic [LFSR_W-1:0]  lfsr_s;
    logic               start_rise_s, jump_rise_s, in_run_s, collision_s, tick_s, spawn_s;

    assign start_rise_s = bus.start_btn_i & ~start_prev_q;
    assign jump_rise_s  = bus.jump_btn_i & ~jump_prev_q;
    assign in_run_s     = (state_q == ST_RUN);
    assign collision_s  = in_run_s & bus.obst_line_i[DINO_COL] & ~dino_up_q;
    // A tick swallowed by a collision does not advance anything.
    assign tick_s       = in_run_s & ~collision_s & (presc_q == PRESC_MAX);
    assign spawn_s      = tick_s & (gap_q >= GAP_MAX) & lfsr_fb(lfsr_s);

    dino_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (tick_s),
        .value_o (lfsr_s)
    );

    // Jump timer next state: a fresh load beats a same-cycle tick decrement.
    always_comb begin
        jump_cnt_d = jump_cnt_q;
        if (in_run_s && !collision_s) begin
            if (jump_rise_s && (jump_cnt_q == JW'(0))) begin
                jump_cnt_d = JUMP_LOAD;
            end else if (tick_s && (jump_cnt_q != JW'(0))) begin
                jump_cnt_d = jump_cnt_q - JW'(1);
            end else begin
                jump_cnt_d = jump_cnt_q;
            end
        end else if (!in_run_s && start_rise_s) begin
            jump_cnt_d = JW'(0);
        end else begin
            jump_cnt_d = jump_cnt_q;
        end
    end

    // Game FSM with all status and command outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            jump_prev_q  <= 1'b0;
            presc_q      <= PW'(0);
            gap_q        <= GW'(0);
            jump_cnt_q   <= JW'(0);
            score_q      <= SCORE_W'(0);
            step_q       <= 1'b0;
            spawn_q      <= 1'b0;
            clear_q      <= 1'b0;
            dino_up_q    <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            start_prev_q <= bus.start_btn_i;
            jump_prev_q  <= bus.jump_btn_i;
            jump_cnt_q   <= jump_cnt_d;
            step_q       <= 1'b0;
            spawn_q      <= 1'b0;
            clear_q      <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DEAD: begin
                    presc_q   <= PW'(0);
                    dino_up_q <= 1'b0;
                    if (start_rise_s) begin
                        state_q     <= ST_RUN;
                        clear_q     <= 1'b1;
                        score_q     <= SCORE_W'(0);
                        gap_q       <= GW'(0);
                        game_over_q <= 1'b0;
                    end else begin
                        state_q     <= state_q;
                        game_over_q <= (state_q == ST_DEAD);
                    end
                end
                ST_RUN: begin
                    if (collision_s) begin
                        state_q     <= ST_DEAD;
                        game_over_q <= 1'b1;
                        presc_q     <= PW'(0);
                        dino_up_q   <= 1'b0;
                    end else begin
                        state_q     <= ST_RUN;
                        game_over_q <= 1'b0;
                        dino_up_q   <= (jump_cnt_d != JW'(0));
                        presc_q     <= tick_s ? PW'(0) : presc_q + PW'(1);
                        if (tick_s) begin
                            step_q  <= 1'b1;
                            spawn_q <= spawn_s;
                            if (spawn_s) begin
                                gap_q <= GW'(0);
                            end else if (gap_q >= GAP_MAX) begin
                                gap_q <= GAP_MAX;
                            end else begin
                                gap_q <= gap_q + GW'(1);
                            end
                            if (score_q != {SCORE_W{1'b1}}) begin
                                score_q <= score_q + SCORE_W'(1);
                            end else begin
                                score_q <= score_q;
                            end
                        end else begin
                            gap_q   <= gap_q;
                            score_q <= score_q;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    presc_q     <= PW'(0);
                    dino_up_q   <= 1'b0;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.obst_step_o  = step_q;
    assign bus.obst_spawn_o = spawn_q;
    assign bus.obst_clear_o = clear_q;
    assign bus.dino_up_o    = dino_up_q;
    assign bus.game_over_o  = game_over_q;
    assign bus.score_o      = score_q;
    assign bus.state_o      = state_q;
endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
Game sequencer for the 8-LED dino runner. It owns the IDLE/RUN/DEAD state machine and divides clk into scroll ticks. It commands obstacle_generator (step, spawn, clear) from an LFSR with a minimum-gap rule, and runs the dino jump timer. It also detects collision against the obstacle line and keeps the score.

Parameters:
TICK_DIV, 4, clk cycles per scroll tick (>=2)
JUMP_TICKS, 3, scroll ticks the dino stays airborne per jump (>=1)
MIN_GAP, 2, minimum empty ticks between spawns
SCORE_W, 8, score counter width
LFSR_SEED, 8'hA5, LFSR reset value (must be nonzero)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start_btn  input  1  start/restart button, already synchronised level
jump_btn  input  1  jump button, already synchronised level
obst_line  input  8  obstacle_generator ledLine; bit0 = dino column
obst_step  output  1  one-cycle pulse: shift obstacles one LED
obst_spawn  output  1  one-cycle pulse, coincident with obst_step: insert obstacle at bit7
obst_clear  output  1  one-cycle pulse: clear obstacle line
dino_up  output  1  dino airborne
game_over  output  1  high in DEAD
score  output  SCORE_W  ticks survived, saturating
state  output  2  current FSM state

Behaviour:
- reset==0: asynchronously drive state=IDLE; all outputs 0; prescaler=0, gap_cnt=0, jump_cnt=0, score=0, LFSR=LFSR_SEED. This holds even mid-RUN.
- Edge detect: start_rise / jump_rise = level & ~registered previous level. Previous-level registers reset to 0.
- All outputs are registered, so effects appear the cycle after the deciding edge.
- FSM (IDLE=00, RUN=01, DEAD=10):
  - IDLE --start_rise--> RUN
  - RUN --collision--> DEAD
  - DEAD --start_rise--> RUN
  - Other inputs are ignored in IDLE/DEAD.
- Entering RUN:
  - obst_clear=1 for exactly the first RUN cycle.
  - score, jump_cnt, gap_cnt and prescaler clear to 0.
  - LFSR is not reseeded.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1, then wraps.
  - tick = (count==TICK_DIV-1). The first tick follows TICK_DIV cycles after entry.
  - Held at 0 outside RUN.
- On tick (RUN, no collision this cycle):
  - obst_step=1 for one cycle.
  - LFSR advances: 8-bit Fibonacci, taps 8,6,5,4; shift left, feedback into bit0.
  - spawn = (gap_cnt>=MIN_GAP) & lfsr_next[0]. If spawn: obst_spawn=1 and gap_cnt=0; else gap_cnt increments, saturating at MIN_GAP.
  - score increments, saturating at all-ones.
  - If jump_cnt>0, jump_cnt decrements.
- Jump:
  - jump_rise in RUN with jump_cnt==0 loads jump_cnt=JUMP_TICKS.
  - jump_rise while airborne is ignored.
  - Load in the same cycle as a tick: load wins, no decrement.
  - dino_up = (jump_cnt!=0), registered.
- Collision = RUN & obst_line[0] & ~dino_up, evaluated every cycle.
  - Collision has priority over tick: no step, spawn or score change that cycle.
  - Next cycle: state=DEAD, game_over=1.
- DEAD:
  - score, jump_cnt and LFSR frozen; dino_up forced 0; obst_step, obst_spawn and obst_clear stay 0.
  - game_over drops in the same cycle state becomes RUN.
- start_rise in the same cycle as a collision: the collision is taken, and the start edge is consumed without effect.

Decomposition:
- Shared package dino_pkg holds:
  - state encodings ST_IDLE/ST_RUN/ST_DEAD
  - LFSR width and tap mask 8'hB8
  - DINO_COL=0 and LINE_W=8
- One sub-module, dino_lfsr8: clk, reset, seed parameter, advance enable, 8-bit value. It is reused later by obstacle_generator.

Test Plan:
- Reset low mid-sequence -> same cycle: state=00, score=0, all pulses 0, dino_up=0, game_over=0. Hold 3 cycles, release -> remains IDLE.
- start_btn 0->1 in IDLE, obst_line=0 -> obst_clear high 1 cycle, state=01. obst_step every 4 cycles. score = 1,2,3 after 3 ticks.
- RUN, drive obst_line=8'b0000_0001 with dino_up=0 -> next cycle state=10, game_over=1. score frozen and no obst_step for 20 cycles.
- jump_btn pulse, then obst_line[0]=1 during the next 2 ticks -> no DEAD. dino_up falls after exactly 3 ticks. A second jump_rise while airborne does not extend it.
- RUN 64 ticks, obst_line=0, MIN_GAP=2 -> every obst_spawn coincides with obst_step. At least 2 non-spawn ticks between spawns. Spawn pattern matches the LFSR model seeded 8'hA5.
- In DEAD, start_rise -> obst_clear pulse, score=0, state=01. Score counts from 1 again at the first tick.
